// File: rtl/micro_op_queue.sv
// Micro-op queue between decode and register read: multi-push, multi-pop circular FIFO
// with flush on redirect, occupancy reporting and sticky overflow/underflow flags.
package micro_op_pkg;
  typedef enum logic [3:0] {
    m_nop, m_add, m_sub, m_and, m_or, m_ld, m_st, m_jb, m_jnb, m_jz, m_jnz, m_jmp
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] rip_val;
  } micro_op_t;
endpackage

module micro_op_queue
  import micro_op_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 4,
  parameter int DEQ_W = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [$clog2(ENQ_W+1)-1:0]     enq_count,
  input  micro_op_t [ENQ_W-1:0]          enq_mop,
  output logic                           enq_ready,
  output logic [$clog2(DEQ_W+1)-1:0]     deq_avail,
  output micro_op_t [DEQ_W-1:0]          deq_mop,
  input  logic [$clog2(DEQ_W+1)-1:0]     deq_count,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           overflow_err,
  output logic                           underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int EC_W  = $clog2(ENQ_W + 1);
  localparam int DC_W  = $clog2(DEQ_W + 1);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  micro_op_t        mem [DEPTH];

  logic [OCC_W-1:0] free;
  logic             push_req;
  logic             push_ok;
  logic             pop_ok;
  logic [OCC_W-1:0] enq_acc;
  logic [OCC_W-1:0] deq_acc;

  // Ready and availability come from registered occupancy only, so no input reaches an output.
  always_comb begin
    free      = OCC_W'(DEPTH) - occupancy;
    enq_ready = free >= OCC_W'(ENQ_W);
    deq_avail = (occupancy >= OCC_W'(DEQ_W)) ? DC_W'(DEQ_W) : DC_W'(occupancy);
    push_req  = enq_count != '0;
    push_ok   = push_req && enq_ready && (enq_count <= EC_W'(ENQ_W));
    pop_ok    = deq_count <= deq_avail;
    enq_acc   = push_ok ? OCC_W'(enq_count) : '0;
    deq_acc   = pop_ok ? OCC_W'(deq_count) : '0;
    for (int j = 0; j < DEQ_W; j++) begin
      deq_mop[j] = mem[head + PTR_W'(j)];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (push_ok && !flush && (EC_W'(i) < enq_count)) begin
        mem[tail + PTR_W'(i)] <= enq_mop[i];
      end
    end
  end

  // Flush wins over any same-cycle push/pop and masks both error checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      occupancy     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + PTR_W'(enq_count);
      end
      if (pop_ok) begin
        head <= head + PTR_W'(deq_count);
      end
      occupancy <= occupancy + enq_acc - deq_acc;
      if (push_req && !push_ok) begin
        overflow_err <= 1'b1;
      end
      if (!pop_ok) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_micro_op_queue.sv
// Randomised bench for micro_op_queue against a queue-based reference model.
module tb_micro_op_queue;
  import micro_op_pkg::*;

  localparam int DEPTH = 16;
  localparam int ENQ_W = 4;
  localparam int DEQ_W = 2;
  localparam int EC_W  = $clog2(ENQ_W + 1);
  localparam int DC_W  = $clog2(DEQ_W + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  flush = 1'b0;
  logic [EC_W-1:0]       enq_count = '0;
  micro_op_t [ENQ_W-1:0] enq_mop = '0;
  logic                  enq_ready;
  logic [DC_W-1:0]       deq_avail;
  micro_op_t [DEQ_W-1:0] deq_mop;
  logic [DC_W-1:0]       deq_count = '0;
  logic [OCC_W-1:0]      occupancy;
  logic                  overflow_err;
  logic                  underflow_err;

  micro_op_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_count(enq_count), .enq_mop(enq_mop), .enq_ready(enq_ready),
    .deq_avail(deq_avail), .deq_mop(deq_mop), .deq_count(deq_count),
    .occupancy(occupancy), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  micro_op_t mq[$];
  bit        m_ovf = 1'b0;
  bit        m_unf = 1'b0;
  micro_op_t [ENQ_W-1:0] mops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_avail();
    return (mq.size() < DEQ_W) ? mq.size() : DEQ_W;
  endfunction

  function automatic micro_op_t rand_mop(input int rip);
    micro_op_t m;
    m.opcode  = opcode_t'($urandom_range(0, 11));
    m.dst     = 5'($urandom);
    m.src1    = 5'($urandom);
    m.src2    = 5'($urandom);
    m.rip_val = 32'(rip);
    return m;
  endfunction

  task automatic model_update(input int ec, input int dc, input bit fl);
    bit good_push;
    if (fl) begin
      mq.delete();
    end else begin
      good_push = (ec > 0) && ((DEPTH - mq.size()) >= ENQ_W) && (ec <= ENQ_W);
      if (ec > 0 && !good_push) m_ovf = 1'b1;
      if (dc > m_avail()) m_unf = 1'b1;
      else repeat (dc) void'(mq.pop_front());
      if (good_push) for (int i = 0; i < ec; i++) mq.push_back(mops[i]);
    end
  endtask

  task automatic check_all(input string tag);
    int av;
    av = m_avail();
    chk({tag, "_occ"}, 64'(occupancy), 64'(mq.size()));
    chk({tag, "_rdy"}, 64'(enq_ready), 64'((DEPTH - mq.size()) >= ENQ_W));
    chk({tag, "_avail"}, 64'(deq_avail), 64'(av));
    for (int j = 0; j < av; j++) chk({tag, "_mop"}, 64'(deq_mop[j]), 64'(mq[j]));
    chk({tag, "_ovf"}, 64'(overflow_err), 64'(m_ovf));
    chk({tag, "_unf"}, 64'(underflow_err), 64'(m_unf));
  endtask

  task automatic step(input int ec, input int dc, input bit fl, input string tag);
    enq_count = EC_W'(ec);
    deq_count = DC_W'(dc);
    flush     = fl;
    enq_mop   = mops;
    @(posedge clk);
    model_update(ec, dc, fl);
    @(negedge clk);
    enq_count = '0;
    deq_count = '0;
    flush     = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rip;
    int ec;
    int dc;
    int sent;
    int next_rip;
    bit fl;
    rip = 100;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all("reset");

    // single push of three
    mops = '0;
    mops[0] = rand_mop(1); mops[0].opcode = m_add;
    mops[1] = rand_mop(2); mops[1].opcode = m_ld;
    mops[2] = rand_mop(3); mops[2].opcode = m_st;
    step(3, 0, 1'b0, "push3");
    chk("push3_occ3", 64'(occupancy), 64'(3));
    chk("push3_avail2", 64'(deq_avail), 64'(2));
    chk("push3_op0", 64'(deq_mop[0].opcode), 64'(m_add));
    chk("push3_op1", 64'(deq_mop[1].opcode), 64'(m_ld));

    // fill to full, then overflow
    step(0, 0, 1'b1, "flush0");
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < ENQ_W; i++) mops[i] = rand_mop(rip + i);
      rip += ENQ_W;
      step(ENQ_W, 0, 1'b0, "fill");
      chk("fill_occ", 64'(occupancy), 64'((k < 4) ? 4 * (k + 1) : 16));
      chk("fill_rdy", 64'(enq_ready), 64'((k < 3) ? 1 : 0));
    end
    chk("fill_ovf", 64'(overflow_err), 64'(1));

    // simultaneous push and pop at occupancy 6
    step(0, 0, 1'b1, "flush1");
    for (int i = 0; i < ENQ_W; i++) mops[i] = rand_mop(200 + i);
    step(4, 0, 1'b0, "sim_a");
    for (int i = 0; i < ENQ_W; i++) mops[i] = rand_mop(204 + i);
    step(2, 0, 1'b0, "sim_b");
    for (int i = 0; i < ENQ_W; i++) mops[i] = rand_mop(206 + i);
    step(4, 2, 1'b0, "sim_c");
    chk("sim_occ8", 64'(occupancy), 64'(8));
    chk("sim_head", 64'(deq_mop[0].rip_val), 64'(202));

    // flush priority at occupancy 10
    for (int i = 0; i < ENQ_W; i++) mops[i] = rand_mop(300 + i);
    step(2, 0, 1'b0, "fp_a");
    chk("fp_occ10", 64'(occupancy), 64'(10));
    step(4, 2, 1'b1, "fp_b");
    chk("fp_occ0", 64'(occupancy), 64'(0));
    chk("fp_rdy", 64'(enq_ready), 64'(1));
    chk("fp_ovf_kept", 64'(overflow_err), 64'(1));

    // wrap stream: 40 ops, push 3 / pop 2 per cycle, then drain
    sent = 0;
    next_rip = 0;
    while (sent < 40 || mq.size() > 0) begin
      ec = ((40 - sent) > 3) ? 3 : (40 - sent);
      dc = m_avail();
      if ((DEPTH - mq.size()) < ENQ_W) ec = 0;
      for (int i = 0; i < ec; i++) mops[i] = rand_mop(sent + i);
      for (int j = 0; j < dc; j++) begin
        chk("wrap_rip", 64'(deq_mop[j].rip_val), 64'(next_rip));
        next_rip++;
      end
      step(ec, dc, 1'b0, "wrap");
      sent += ec;
    end
    chk("wrap_total", 64'(next_rip), 64'(40));

    // randomised traffic
    for (int c = 0; c < 300; c++) begin
      ec = $urandom_range(0, ENQ_W);
      dc = $urandom_range(0, 3);
      fl = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < ENQ_W; i++) mops[i] = rand_mop(rip + i);
      rip += ENQ_W;
      step(ec, dc, fl, "rand");
    end

    // async reset between edges with a non-empty queue
    for (int i = 0; i < ENQ_W; i++) mops[i] = rand_mop(500 + i);
    step(0, 0, 1'b1, "pre_rst");
    step(4, 0, 1'b0, "pre_rst_push");
    #2 reset = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_ovf", 64'(overflow_err), 64'(0));
    chk("arst_unf", 64'(underflow_err), 64'(0));
    chk("arst_rdy", 64'(enq_ready), 64'(1));
    chk("arst_avail", 64'(deq_avail), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // underflow at occupancy 1
    mops[0] = rand_mop(600);
    step(1, 0, 1'b0, "unf_a");
    step(0, 2, 1'b0, "unf_b");
    chk("unf_flag", 64'(underflow_err), 64'(1));
    chk("unf_occ1", 64'(occupancy), 64'(1));
    chk("unf_ovf0", 64'(overflow_err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_op_queue.md
Name: micro_op_queue

Overview:
- Parametrised multi-entry FIFO of micro_op_t between the instruction decoder and the register-read stage.
- Decoder pushes up to ENQ_W micro ops per cycle; these are the expansion of one fat_instruction_t.
- Register-read stage pops up to DEQ_W micro ops per cycle, in order.
- Supports a one-cycle flush on redirect (taken m_jb..m_jmp) and reports occupancy.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2 and >= ENQ_W+DEQ_W.
- ENQ_W, 4, maximum micro ops accepted per cycle.
- DEQ_W, 2, maximum micro ops presented and popped per cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries.
- enq_count  in  $clog2(ENQ_W+1)  number of valid micro ops in enq_mop[0..enq_count-1].
- enq_mop  in  ENQ_W x $bits(micro_op_t)  micro ops; slot 0 is oldest.
- enq_ready  out  1  queue can accept a full ENQ_W-wide push this cycle.
- deq_avail  out  $clog2(DEQ_W+1)  number of valid entries presented, min(occupancy, DEQ_W).
- deq_mop  out  DEQ_W x $bits(micro_op_t)  oldest entries; slot 0 is head.
- deq_count  in  $clog2(DEQ_W+1)  number of entries consumed this cycle.
- occupancy  out  $clog2(DEPTH+1)  current valid-entry count.
- overflow_err  out  1  sticky; illegal push attempted.
- underflow_err  out  1  sticky; illegal pop attempted.

Behaviour:
- State: head pointer, tail pointer (log2(DEPTH) bits each, wrap modulo DEPTH), occupancy counter, DEPTH-entry storage array.
- Reset (async, any time including mid-operation):
  - head = tail = occupancy = 0.
  - enq_ready = 1, deq_avail = 0.
  - overflow_err = underflow_err = 0.
  - Storage contents are don't-care.
- enq_ready = (DEPTH - occupancy) >= ENQ_W. It is combinational from registered occupancy only, never from same-cycle deq_count.
- Enqueue:
  - When enq_count > 0 and enq_ready, write enq_mop[i] to entry (tail+i) mod DEPTH for i < enq_count.
  - Then tail += enq_count.
  - A push is all-or-nothing; there are no partial pushes.
- Illegal push (enq_count > 0 with enq_ready = 0):
  - Push is dropped and state is unchanged by it.
  - overflow_err sets.
- Dequeue outputs:
  - deq_mop[j] = entry (head+j) mod DEPTH.
  - Slots j >= deq_avail are don't-care; the bench must not check them.
- Pop:
  - When deq_count <= deq_avail, head += deq_count.
  - When deq_count > deq_avail, the pop is ignored and underflow_err sets.
- Same-cycle push and pop:
  - Both act on pre-edge state.
  - occupancy_next = occupancy + accepted_enq - accepted_deq.
  - No bypass: a newly enqueued entry first appears on deq_mop the cycle after the push edge. Minimum enqueue-to-dequeue latency is 1 cycle.
- Flush:
  - On the edge, head = tail = occupancy = 0, regardless of same-cycle enq_count or deq_count.
  - Both error checks are suppressed that cycle.
  - Error flags are not cleared; only reset clears them.
- Wrap-around: pointers wrap silently at DEPTH; a push or pop spanning the wrap boundary is contiguous modulo DEPTH.
- Full (occupancy == DEPTH):
  - enq_ready = 0.
  - A pop of k entries restores enq_ready on the next cycle once DEPTH - occupancy >= ENQ_W.
- Empty (occupancy == 0): deq_avail = 0; any nonzero deq_count is an underflow.
- All outputs are registered-state derived; there is no combinational path from any input to any output.

Test Plan:
- Reset then single push: enq_count=3 with mops opcode m_add, m_ld, m_st. Next cycle: occupancy=3, deq_avail=2, deq_mop[0].opcode=m_add, deq_mop[1].opcode=m_ld.
- Fill: four cycles of enq_count=4 with no pops. occupancy goes 4, 8, 12, 16; enq_ready=0 once occupancy >= 13. A fifth push sets overflow_err=1 and occupancy stays 16.
- Simultaneous: at occupancy=6, enq_count=4 and deq_count=2 in the same cycle. Next cycle: occupancy=8 and order is preserved (head is the 3rd-oldest old entry).
- Wrap: stream 40 micro ops with rip_val=0..39, pushing 3 and popping 2 per cycle, then drain. Popped rip_val sequence is exactly 0..39 with no gaps or duplicates across pointer wrap.
- Flush priority: at occupancy=10, assert flush together with enq_count=4 and deq_count=2. Next cycle: occupancy=0, deq_avail=0, enq_ready=1, error flags unchanged.
- Underflow and async reset:
  - At occupancy=1, deq_count=2 sets underflow_err=1 and leaves occupancy at 1.
  - Asserting reset between edges immediately gives occupancy=0 and both error flags 0.
